// File: rtl/sram_wr_pkg.sv
// Shared types and constants for the SRAM capture writer.
// The VERIFY state exists only when SRAM_WR_READBACK_EN is defined.
package sram_wr_pkg;

  localparam int unsigned ADDR_W_DEF    = 20;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned WE_CYCLES_MIN = 1;
  localparam int unsigned WE_CYCLES_MAX = 7;
  localparam int unsigned WE_CNT_W      = 3;

`ifdef SRAM_WR_READBACK_EN
  typedef enum logic [2:0] {
    IDLE, ARMED, SETUP, WRITE, HOLD, DONE, VERIFY
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, ARMED, SETUP, WRITE, HOLD, DONE
  } state_e;
`endif

  // Last WRITE-state count value, with the pulse width clamped to its legal range.
  function automatic logic [WE_CNT_W-1:0] we_last(input int unsigned cycles);
    int unsigned c;
    c = cycles;
    if (c < WE_CYCLES_MIN) c = WE_CYCLES_MIN;
    if (c > WE_CYCLES_MAX) c = WE_CYCLES_MAX;
    return WE_CNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/sram_wr_addr_ctr.sv
// SRAM word address and completed-write counter; neither moves past the
// configured window.
module sram_wr_addr_ctr
  import sram_wr_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] LAST_ADDR = '1
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              load,
  input  logic              commit,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   count,
  output logic              at_last_c
);

  localparam logic [ADDR_W:0] CNT_MAX =
    (ADDR_W+1)'(LAST_ADDR) - (ADDR_W+1)'(BASE_ADDR) + (ADDR_W+1)'(1);

  assign at_last_c = (addr == LAST_ADDR);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      addr  <= BASE_ADDR;
      count <= '0;
    end else if (load) begin
      addr  <= BASE_ADDR;
      count <= '0;
    end else begin
      if (commit && (count != CNT_MAX)) count <= count + (ADDR_W+1)'(1);
      if (advance && !at_last_c)        addr  <= addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/sram_writing_fsm.sv
// Streams handshaked 16-bit samples into consecutive SRAM words.
// Define SRAM_WR_READBACK_EN to read back and check every written word.
module sram_writing_fsm
  import sram_wr_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(20'hFFFFF),
  parameter int unsigned       WE_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic [ADDR_W:0]   words_written,
  output logic              busy,
  output logic              done,
  output logic              verify_err
);

  localparam logic [WE_CNT_W-1:0] WE_LAST = we_last(WE_CYCLES);

  state_e              state;
  logic [1:0]          rst_sync;
  logic                stop_pend;
  logic                strobe_n;
  logic [WE_CNT_W-1:0] we_cnt;
  logic                rst_ok_c;
  logic                at_last_c;
  logic                arm_c;
  logic                wr_end_c;
  logic                finish_c;

  // Release from reset only counts once it has been seen on two clock edges.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_ok_c  = rst_sync[1];
  assign SRAM_CE_N = strobe_n;
  assign SRAM_UB_N = strobe_n;
  assign SRAM_LB_N = strobe_n;

`ifdef SRAM_WR_READBACK_EN
  logic v_phase;
`endif

  always_comb begin
    arm_c    = ((state == IDLE) || (state == DONE)) && start && rst_ok_c;
    finish_c = at_last_c || stop_pend || stop;
`ifdef SRAM_WR_READBACK_EN
    wr_end_c = (state == VERIFY) && v_phase;
`else
    wr_end_c = (state == HOLD);
`endif
  end

  sram_wr_addr_ctr #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .LAST_ADDR (LAST_ADDR)
  ) u_addr_ctr (
    .Clk       (Clk),
    .reset     (reset),
    .load      (arm_c),
    .commit    (state == HOLD),
    .advance   (wr_end_c && !finish_c),
    .addr      (SRAM_ADDR),
    .count     (words_written),
    .at_last_c (at_last_c)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      din_ready   <= 1'b0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      strobe_n    <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      stop_pend   <= 1'b0;
      we_cnt      <= '0;
`ifdef SRAM_WR_READBACK_EN
      v_phase     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm_c) begin
            state     <= ARMED;
            din_ready <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            stop_pend <= 1'b0;
          end
        end
        // stop takes priority over a word offered in the same cycle
        ARMED: begin
          if (stop) begin
            state     <= DONE;
            din_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (din_valid) begin
            state       <= SETUP;
            din_ready   <= 1'b0;
            sram_dq_out <= din;
            sram_dq_oe  <= 1'b1;
            strobe_n    <= 1'b0;
          end
        end
        SETUP: begin
          stop_pend <= stop_pend | stop;
          state     <= WRITE;
          SRAM_WE_N <= 1'b0;
          we_cnt    <= '0;
        end
        WRITE: begin
          stop_pend <= stop_pend | stop;
          if (we_cnt == WE_LAST) begin
            state     <= HOLD;
            SRAM_WE_N <= 1'b1;
          end else begin
            we_cnt <= we_cnt + WE_CNT_W'(1);
          end
        end
        HOLD: begin
          stop_pend <= stop_pend | stop;
`ifdef SRAM_WR_READBACK_EN
          state      <= VERIFY;
          sram_dq_oe <= 1'b0;
          SRAM_OE_N  <= 1'b0;
          v_phase    <= 1'b0;
`endif
        end
`ifdef SRAM_WR_READBACK_EN
        VERIFY: begin
          stop_pend <= stop_pend | stop;
          v_phase   <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase

      // End of a write cycle: release the bus, then stop or ask for the next word.
      if (wr_end_c) begin
        strobe_n   <= 1'b1;
        sram_dq_oe <= 1'b0;
        SRAM_OE_N  <= 1'b1;
        SRAM_WE_N  <= 1'b1;
        if (finish_c) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state     <= ARMED;
          din_ready <= 1'b1;
        end
      end
    end
  end

`ifdef SRAM_WR_READBACK_EN
  // Sticky until the next capture is armed.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset)
      verify_err <= 1'b0;
    else if (arm_c)
      verify_err <= 1'b0;
    else if ((state == VERIFY) && v_phase && (SRAM_DQ != sram_dq_out))
      verify_err <= 1'b1;
  end
`else
  logic unused_dq_c;
  assign unused_dq_c = ^SRAM_DQ;
  assign verify_err  = 1'b0;
`endif

endmodule
